ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and issues in-order instruction-memory requests.
- Collects responses into a small reservation queue and presents instructions plus their addresses to the decode stage with a valid/ready handshake.
- Drives a hold request back toward the PC register whenever a fetch cannot be issued.
- Discards in-flight responses after a jump/flush.

Parameters:
ADDR_W, 64, instruction address width.
INST_W, 32, instruction width.
DEPTH, 4, queue entries, including in-flight requests; power of two, ≥2.
NOP_INST, 32'h00000013, value driven on inst_o when inst_valid_o=0.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
pc_i  in  ADDR_W  current PC.
flush_i  in  1  jump taken this cycle; kill all queued and in-flight fetches.
pc_hold_o  out  1  1 = PC register must hold (fetch of pc_i not accepted).
req_valid_o  out  1  memory request valid.
req_ready_i  in  1  memory accepts request.
req_addr_o  out  ADDR_W  request address: pc_i with bits [1:0] forced 0.
rsp_valid_i  in  1  memory response valid; in order; earliest 1 cycle after acceptance.
rsp_data_i  in  INST_W  response instruction.
inst_valid_o  out  1  head entry filled.
inst_o  out  INST_W  head instruction, or NOP_INST when invalid.
inst_addr_o  out  ADDR_W  head instruction address; 0 when invalid.
id_ready_i  in  1  decode consumes head when inst_valid_o=1.

Behaviour:
- Entry contents: addr, data, filled.
- Pointers: wr_ptr (alloc), fill_ptr (next to fill), rd_ptr (head), count (allocated entries).
- drop_cnt (log2(DEPTH)+1 bits): responses still owed for killed requests.

Reset:
- All pointers, count, drop_cnt and every filled bit = 0.
- Outputs: req_valid_o=0, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, pc_hold_o=1.
- rst dominates every other input, including mid-transfer.
- Responses to requests issued before reset are not tracked and must not arrive after reset; bench must not send them.

Issue:
- req_valid_o = !flush_i && (count + drop_cnt < DEPTH).
- On req_valid_o && req_ready_i, allocate entry at wr_ptr with addr=pc_i, filled=0.
- pc_hold_o = !(req_valid_o && req_ready_i); combinational.
- On flush the PC register loads the jump target regardless of pc_hold_o.

Response:
- If drop_cnt>0: discard, drop_cnt−1.
- Else write data into fill_ptr entry, set filled, advance fill_ptr.

Output and timing:
- inst_valid_o = filled[rd_ptr].
- On inst_valid_o && id_ready_i: clear entry, advance rd_ptr, count−1.
- Request accepted in cycle T with response in T+1 gives inst_valid_o in T+2.
- Sustained throughput is 1 instruction/cycle.

Flush, cycle F:
- Clear all entries.
- drop_cnt_next = drop_cnt + (allocated-but-unfilled entries) − rsp_valid_i.
- No issue in F.
- Any decode handshake in F is ignored; the instruction is discarded.
- First fetch of the target is issued in F+1.

Simultaneous events:
- Allocate, fill and pop in one cycle: count changes by net (alloc − pop).
- Full queue (count+drop_cnt=DEPTH) with a pop in the same cycle: no issue this cycle; issue resumes next cycle. No combinational ready→valid path.
- rsp_valid_i with nothing owed: ignored, sim-only error message.

Wrap-around:
- Pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt_o (64) and perf_drop_cnt_o (64), reset 0, non-saturating wrap.
  - perf_fetch_cnt_o: +1 per decode handshake, excluding flush cycles.
  - perf_drop_cnt_o: +1 per discarded response, plus the number of filled entries cleared by flush.
- Undefined: ports and counters absent; functionality otherwise identical.

Test Plan:
- Reset: hold rst 3 cycles with req_ready_i=1 → req_valid_o=0, inst_valid_o=0, inst_o=0x00000013, pc_hold_o=1; first request in the first cycle after rst deasserts.
- Streaming: PC 0x80000000 with +4 increments, req_ready_i=1, 1-cycle memory, id_ready_i=1 → inst_addr_o 0x80000000, 0x80000004, … on consecutive cycles from T+2; pc_hold_o=0 throughout.
- Backpressure: id_ready_i=0 with DEPTH=4 → exactly 4 requests accepted, then req_valid_o=0 and pc_hold_o=1. After id_ready_i=1, the 4 instructions drain in order with no loss or duplication.
- Flush with 2 in flight: flush_i with target 0x80001000 → both late responses discarded (drop_cnt 2→0). The next inst_addr_o is 0x80001000 and inst_valid_o stays 0 until it arrives.
- Flush coincident with a response and a decode handshake → response and head both discarded, drop_cnt_next = unfilled−1, no instruction delivered from the old stream.
- Reset mid-operation: rst asserted with 3 filled entries → next cycle inst_valid_o=0 and the queue is empty; no stale entries delivered; with IFU_PERF_CNT_EN both counters are 0.

Source files
------------

// File: rtl/ifu_fetch_queue_if.sv
// Handshake bundle linking the fetch queue to the PC register, instruction memory and decode.
// master = fetch queue, slave = surrounding pipeline / memory.
interface ifu_fetch_queue_if #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
);
   logic [ADDR_W-1:0] pc_i;
   logic              flush_i;
   logic              pc_hold_o;
   logic              req_valid_o;
   logic              req_ready_i;
   logic [ADDR_W-1:0] req_addr_o;
   logic              rsp_valid_i;
   logic [INST_W-1:0] rsp_data_i;
   logic              inst_valid_o;
   logic [INST_W-1:0] inst_o;
   logic [ADDR_W-1:0] inst_addr_o;
   logic              id_ready_i;

   modport master (
      input  pc_i, flush_i, req_ready_i, rsp_valid_i, rsp_data_i, id_ready_i,
      output pc_hold_o, req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_addr_o
   );

   modport slave (
      output pc_i, flush_i, req_ready_i, rsp_valid_i, rsp_data_i, id_ready_i,
      input  pc_hold_o, req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_addr_o
   );
endinterface

// File: rtl/ifu_fetch_queue.sv
// In-order instruction fetch queue: issues PC requests, collects responses, hands them to decode.
// Optional performance counters are enabled with the IFU_PERF_CNT_EN macro.
module ifu_fetch_queue #(
   parameter int                ADDR_W   = 64,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
`ifdef IFU_PERF_CNT_EN
   output logic [63:0]       perf_fetch_cnt_o,
   output logic [63:0]       perf_drop_cnt_o,
`endif
   ifu_fetch_queue_if.master bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [INST_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]  filled_reg;
   logic [DEPTH-1:0]  filled_next;
   logic [DEPTH-1:0]  fill_hit;
   logic [DEPTH-1:0]  pop_hit;

   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  fill_ptr_reg, fill_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [CNT_W-1:0]  pend_reg, pend_next;
   logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;

   logic has_room;
   logic req_valid;
   logic issue;
   logic rsp_owed;
   logic rsp_drop;
   logic rsp_fill;
   logic head_valid;
   logic pop;

   // Killed requests (drop_cnt) still occupy memory slots, so they count against capacity.
   always_comb begin
      has_room   = ({1'b0, count_reg} + {1'b0, drop_cnt_reg}) < DEPTH_W;
      req_valid  = !rst && !bus.flush_i && has_room;
      issue      = req_valid && bus.req_ready_i;
      rsp_owed   = (drop_cnt_reg != '0) || (pend_reg != '0);
      rsp_drop   = !rst && bus.rsp_valid_i &&
                   (bus.flush_i ? rsp_owed : (drop_cnt_reg != '0));
      rsp_fill   = !rst && !bus.flush_i && bus.rsp_valid_i &&
                   (drop_cnt_reg == '0) && (pend_reg != '0);
      head_valid = !rst && filled_reg[rd_ptr_reg];
      pop        = head_valid && bus.id_ready_i && !bus.flush_i;
   end

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      fill_ptr_next = fill_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      pend_next     = pend_reg;
      drop_cnt_next = drop_cnt_reg;
      if (bus.flush_i) begin
         wr_ptr_next   = '0;
         fill_ptr_next = '0;
         rd_ptr_next   = '0;
         count_next    = '0;
         pend_next     = '0;
         // Every unfilled entry becomes an owed response; one may be retiring right now.
         drop_cnt_next = drop_cnt_reg + pend_reg - CNT_W'(rsp_drop);
      end else begin
         if (issue)    wr_ptr_next   = wr_ptr_reg + PTR_W'(1);
         if (rsp_fill) fill_ptr_next = fill_ptr_reg + PTR_W'(1);
         if (pop)      rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
         count_next    = count_reg + CNT_W'(issue) - CNT_W'(pop);
         pend_next     = pend_reg + CNT_W'(issue) - CNT_W'(rsp_fill);
         drop_cnt_next = drop_cnt_reg - CNT_W'(rsp_drop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         fill_ptr_reg <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         pend_reg     <= '0;
         drop_cnt_reg <= '0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         fill_ptr_reg <= fill_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         pend_reg     <= pend_next;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   // Fill and pop never target the same entry: one needs it unfilled, the other filled.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign fill_hit[gi]    = rsp_fill && (fill_ptr_reg == PTR_W'(gi));
      assign pop_hit[gi]     = pop && (rd_ptr_reg == PTR_W'(gi));
      assign filled_next[gi] = !bus.flush_i && (fill_hit[gi] || (filled_reg[gi] && !pop_hit[gi]));
   end

   always_ff @(posedge clk) begin
      if (rst) filled_reg <= '0;
      else     filled_reg <= filled_next;
   end

   always_ff @(posedge clk) begin
      if (issue)    addr_mem[wr_ptr_reg]   <= bus.pc_i;
      if (rsp_fill) data_mem[fill_ptr_reg] <= bus.rsp_data_i;
   end

   assign bus.req_valid_o  = req_valid;
   assign bus.req_addr_o   = {bus.pc_i[ADDR_W-1:2], 2'b00};
   assign bus.pc_hold_o    = !issue;
   assign bus.inst_valid_o = head_valid;
   assign bus.inst_o       = head_valid ? data_mem[rd_ptr_reg] : NOP_INST;
   assign bus.inst_addr_o  = head_valid ? addr_mem[rd_ptr_reg] : '0;

`ifdef IFU_PERF_CNT_EN
   logic [63:0] perf_fetch_reg;
   logic [63:0] perf_drop_reg;
   logic [63:0] flush_kill;

   // A flush throws away every filled entry, including a head decode tried to take.
   assign flush_kill = bus.flush_i ? 64'($countones(filled_reg)) : 64'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_reg <= '0;
         perf_drop_reg  <= '0;
      end else begin
         perf_fetch_reg <= perf_fetch_reg + 64'(pop);
         perf_drop_reg  <= perf_drop_reg + 64'(rsp_drop) + flush_kill;
      end
   end

   assign perf_fetch_cnt_o = perf_fetch_reg;
   assign perf_drop_cnt_o  = perf_drop_reg;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      assert (rst || !bus.rsp_valid_i || rsp_owed)
         else $error("ifu_fetch_queue: response received with nothing outstanding");
   end
`endif
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: directed vector table, then randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_ifu_fetch_queue;
   localparam int          ADDR_W = 64;
   localparam int          INST_W = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ifu_fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

`ifdef IFU_PERF_CNT_EN
   logic [63:0] perf_fetch_cnt;
   logic [63:0] perf_drop_cnt;
`endif

   ifu_fetch_queue #(
      .ADDR_W   (ADDR_W),
      .INST_W   (INST_W),
      .DEPTH    (DEPTH),
      .NOP_INST (NOP)
   ) dut (
      .clk              (clk),
      .rst              (rst),
`ifdef IFU_PERF_CNT_EN
      .perf_fetch_cnt_o (perf_fetch_cnt),
      .perf_drop_cnt_o  (perf_drop_cnt),
`endif
      .bus              (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          r, fl, rr, rsp, id;
      logic [63:0] pc;
      bit          rv, hold, iv;
      logic [63:0] addr;
      bit          perf0;
   } vec_t;

   typedef struct {
      logic [63:0] addr;
      bit          filled;
      logic [31:0] data;
   } ent_t;

   vec_t        vec[$];
   logic [63:0] mem_q[$];   // addresses accepted by memory, response still owed
   ent_t        mq[$];      // reference queue: allocated entries, oldest first
   int          drop;
   longint      pf, pd;

   function automatic logic [31:0] memdata(input logic [63:0] a);
      return a[31:0] ^ 32'h5EED_0001;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input bit r, fl, rr, rsp, id, input logic [63:0] pc,
                      input bit rv, hold, iv, input logic [63:0] a, input bit p0);
      vec_t v;
      v.r = r; v.fl = fl; v.rr = rr; v.rsp = rsp; v.id = id; v.pc = pc;
      v.rv = rv; v.hold = hold; v.iv = iv; v.addr = a; v.perf0 = p0;
      vec.push_back(v);
   endtask

   task automatic drive(input bit r, fl, rr, rsp, id, input logic [63:0] pc);
      rst             = r;
      bus.flush_i     = fl;
      bus.req_ready_i = rr;
      bus.id_ready_i  = id;
      bus.pc_i        = pc;
      bus.rsp_valid_i = rsp && (mem_q.size() > 0);
      bus.rsp_data_i  = bus.rsp_valid_i ? memdata(mem_q[0]) : 32'($urandom);
      if (bus.rsp_valid_i) void'(mem_q.pop_front());
   endtask

   initial begin
      logic [63:0] A, T, U, V, W, pc_reg;
      logic [98:0] exp_v;
      bit          r, fl, rr, rsp, id, exp_rv, exp_hold, exp_iv, do_pop;
      logic [31:0] rdata;
      int          unf, fil;

      drive(1, 0, 1, 0, 1, 64'h0);

      A = 64'h8000_0000; T = 64'h8000_1000; U = 64'h8000_2000;
      V = 64'h8000_3000; W = 64'h8000_4000;
      //   r fl rr rsp id pc        rv hold iv addr     perf0
      add(1, 0, 1, 0, 1, A,        0, 1, 0, 64'h0,   0);
      add(1, 0, 1, 0, 1, A,        0, 1, 0, 64'h0,   0);
      add(1, 0, 1, 0, 1, A,        0, 1, 0, 64'h0,   1);
      add(0, 0, 1, 0, 1, A,        1, 0, 0, 64'h0,   0);
      add(0, 0, 1, 1, 1, A+4,      1, 0, 0, 64'h0,   0);
      add(0, 0, 1, 1, 1, A+8,      1, 0, 1, A,       0);
      add(0, 0, 1, 1, 1, A+'hC,    1, 0, 1, A+4,     0);
      add(0, 0, 1, 1, 1, A+'h10,   1, 0, 1, A+8,     0);
      add(0, 0, 1, 1, 0, A+'h14,   1, 0, 1, A+'hC,   0);
      add(0, 0, 1, 1, 0, A+'h18,   1, 0, 1, A+'hC,   0);
      add(0, 0, 1, 1, 0, A+'h1C,   0, 1, 1, A+'hC,   0);
      add(0, 0, 1, 0, 0, A+'h1C,   0, 1, 1, A+'hC,   0);
      add(0, 0, 1, 0, 1, A+'h1C,   0, 1, 1, A+'hC,   0);
      add(0, 0, 1, 0, 1, A+'h1C,   1, 0, 1, A+'h10,  0);
      add(0, 0, 0, 1, 1, A+'h20,   1, 1, 1, A+'h14,  0);
      add(0, 0, 0, 0, 1, A+'h20,   1, 1, 1, A+'h18,  0);
      add(0, 0, 0, 0, 1, A+'h20,   1, 1, 1, A+'h1C,  0);
      add(0, 0, 0, 0, 1, A+'h20,   1, 1, 0, 64'h0,   0);
      // flush with two requests in flight
      add(0, 0, 1, 0, 1, A+'h20,   1, 0, 0, 64'h0,   0);
      add(0, 0, 1, 0, 1, A+'h24,   1, 0, 0, 64'h0,   0);
      add(0, 1, 1, 0, 1, A+'h28,   0, 1, 0, 64'h0,   0);
      add(0, 0, 1, 1, 1, T,        1, 0, 0, 64'h0,   0);
      add(0, 0, 0, 1, 1, T+4,      1, 1, 0, 64'h0,   0);
      add(0, 0, 0, 1, 1, T+4,      1, 1, 0, 64'h0,   0);
      add(0, 0, 0, 0, 1, T+4,      1, 1, 1, T,       0);
      add(0, 0, 0, 0, 1, T+4,      1, 1, 0, 64'h0,   0);
      // flush coincident with a response and a decode handshake
      add(0, 0, 1, 0, 1, T+4,      1, 0, 0, 64'h0,   0);
      add(0, 0, 1, 1, 1, T+8,      1, 0, 0, 64'h0,   0);
      add(0, 0, 1, 0, 0, T+'hC,    1, 0, 1, T+4,     0);
      add(0, 1, 1, 1, 1, T+'h10,   0, 1, 1, T+4,     0);
      add(0, 0, 1, 1, 1, U,        1, 0, 0, 64'h0,   0);
      add(0, 0, 0, 0, 1, U+4,      1, 1, 0, 64'h0,   0);
      add(0, 0, 0, 1, 1, U+4,      1, 1, 0, 64'h0,   0);
      add(0, 0, 0, 0, 1, U+4,      1, 1, 1, U,       0);
      add(0, 0, 0, 0, 1, U+4,      1, 1, 0, 64'h0,   0);
      // reset with three filled entries
      add(0, 0, 1, 0, 0, V,        1, 0, 0, 64'h0,   0);
      add(0, 0, 1, 1, 0, V+4,      1, 0, 0, 64'h0,   0);
      add(0, 0, 1, 1, 0, V+8,      1, 0, 1, V,       0);
      add(0, 0, 0, 1, 0, V+'hC,    1, 1, 1, V,       0);
      add(1, 0, 1, 0, 1, V+'hC,    0, 1, 0, 64'h0,   0);
      add(0, 0, 0, 0, 1, W,        1, 1, 0, 64'h0,   1);
      add(0, 0, 0, 0, 1, W,        1, 1, 0, 64'h0,   0);

      foreach (vec[i]) begin
         @(negedge clk);
         drive(vec[i].r, vec[i].fl, vec[i].rr, vec[i].rsp, vec[i].id, vec[i].pc);
         #1;
         exp_v = {vec[i].rv, vec[i].hold, vec[i].iv,
                  (vec[i].iv ? memdata(vec[i].addr) : NOP), vec[i].addr};
         check($sformatf("vec%0d", i),
               128'({bus.req_valid_o, bus.pc_hold_o, bus.inst_valid_o, bus.inst_o, bus.inst_addr_o}),
               128'(exp_v));
         if (vec[i].rv) check($sformatf("vec%0d_req_addr", i), 128'(bus.req_addr_o), 128'(vec[i].pc));
`ifdef IFU_PERF_CNT_EN
         if (vec[i].perf0) check($sformatf("vec%0d_perf", i), {perf_fetch_cnt, perf_drop_cnt}, 128'h0);
`endif
         $display("vec %0d: rst=%0b flush=%0b rv=%0b hold=%0b iv=%0b addr=%h",
                  i, vec[i].r, vec[i].fl, bus.req_valid_o, bus.pc_hold_o, bus.inst_valid_o, bus.inst_addr_o);
         if (vec[i].r) mem_q.delete();
         else if (vec[i].rv && vec[i].rr) mem_q.push_back(vec[i].pc);
      end

      // Randomized traffic against the reference queue model.
      pc_reg = 64'h8000_0000;
      drop = 0; pf = 0; pd = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         r   = (i < 2) || ($urandom_range(0, 299) == 0);
         fl  = !r && ($urandom_range(0, 19) == 0);
         rr  = ($urandom_range(0, 3) != 0);
         rsp = !r && (mem_q.size() > 0) && ($urandom_range(0, 9) < 6);
         id  = ($urandom_range(0, 99) < (((i / 200) % 2 == 1) ? 25 : 85));
         drive(r, fl, rr, rsp, id, pc_reg);
         rdata = bus.rsp_data_i;
         #1;
         exp_rv   = !r && !fl && (mq.size() + drop < DEPTH);
         exp_hold = !(exp_rv && rr);
         exp_iv   = !r && (mq.size() > 0) && mq[0].filled;
         exp_v    = {exp_rv, exp_hold, exp_iv,
                     (exp_iv ? mq[0].data : NOP), (exp_iv ? mq[0].addr : 64'h0)};
         check($sformatf("rnd%0d", i),
               128'({bus.req_valid_o, bus.pc_hold_o, bus.inst_valid_o, bus.inst_o, bus.inst_addr_o}),
               128'(exp_v));
         if (exp_rv) check($sformatf("rnd%0d_req_addr", i), 128'(bus.req_addr_o), 128'(pc_reg));
`ifdef IFU_PERF_CNT_EN
         check($sformatf("rnd%0d_perf", i), {perf_fetch_cnt, perf_drop_cnt}, {64'(pf), 64'(pd)});
`endif
         if (r) begin
            mq.delete(); mem_q.delete();
            drop = 0; pf = 0; pd = 0;
         end else if (fl) begin
            unf = 0; fil = 0;
            foreach (mq[k]) if (mq[k].filled) fil++; else unf++;
            pd   += fil + (rsp ? 1 : 0);
            drop  = drop + unf - (rsp ? 1 : 0);
            mq.delete();
            pc_reg = 64'h8000_0000 + 64'({$urandom_range(0, 4095), 2'b00});
         end else begin
            do_pop = exp_iv && id;
            if (rsp) begin
               if (drop > 0) begin
                  drop--;
                  pd++;
               end else begin
                  for (int k = 0; k < mq.size(); k++) begin
                     if (!mq[k].filled) begin
                        mq[k].filled = 1'b1;
                        mq[k].data   = rdata;
                        break;
                     end
                  end
               end
            end
            if (do_pop) begin
               void'(mq.pop_front());
               pf++;
            end
            if (exp_rv && rr) begin
               mq.push_back('{pc_reg, 1'b0, 32'h0});
               mem_q.push_back(pc_reg);
               pc_reg += 4;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
